// File: rtl/matmul_load_sequencer_if.sv
// matmul_load_sequencer_if: host input stream, Matrix_Mul core port and result stream of one sequencer
//   in_valid/in_ready/in_data      host words into the sequencer
//   mm_we/mm_addr/mm_data_wr       core memory write port
//   mm_result/mm_qi/mm_qf          core AB_Transpose and its fixed-point format
//   out_valid/out_ready/out_data   result stream, out_last marks index N-1
//   out_qi/out_qf                  format that goes with the result stream
//   master: the sequencer side, slave: host/core/downstream side
interface matmul_load_sequencer_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDRS_LEN = 7
);
  logic                 in_valid, in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 mm_we;
  logic [ADDRS_LEN-1:0] mm_addr;
  logic [WORD_SIZE-1:0] mm_data_wr, mm_result;
  logic [3:0]           mm_qi, mm_qf;
  logic                 out_valid, out_ready, out_last;
  logic [WORD_SIZE-1:0] out_data;
  logic [3:0]           out_qi, out_qf;
  modport master (
    input  in_valid, in_data, mm_result, mm_qi, mm_qf, out_ready,
    output in_ready, mm_we, mm_addr, mm_data_wr, out_valid, out_data, out_last, out_qi, out_qf
  );
  modport slave (
    output in_valid, in_data, mm_result, mm_qi, mm_qf, out_ready,
    input  in_ready, mm_we, mm_addr, mm_data_wr, out_valid, out_data, out_last, out_qi, out_qf
  );
endinterface

// File: rtl/matmul_load_sequencer.sv
// matmul_load_sequencer: loads N*N+N words into Matrix_Mul, waits, captures N results and streams them out
//   src_clk  clock, rising edge
//   rst_n    asynchronous active-low reset
//   flush    synchronous abort back to IDLE
//   bus      matmul_load_sequencer_if.master (input stream, core port, result stream)
//   busy     high in every state except IDLE
// Requires N >= 2 and SETTLE_CYC, WAIT_CYC, RES_STRIDE >= 1.
module matmul_load_sequencer #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDRS_LEN  = 7,
  parameter int N          = 8,
  parameter int SETTLE_CYC = 4,
  parameter int WAIT_CYC   = 50,
  parameter int RES_STRIDE = 1
) (
  input  logic src_clk,
  input  logic rst_n,
  input  logic flush,
  matmul_load_sequencer_if.master bus,
  output logic busy
);
  localparam int TOT  = N * N + N;
  localparam int CW   = $clog2(TOT + 1);
  localparam int M1   = WAIT_CYC > SETTLE_CYC ? WAIT_CYC : SETTLE_CYC;
  localparam int MAXT = M1 > RES_STRIDE ? M1 : RES_STRIDE;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int JW   = $clog2(N);
  localparam logic [CW-1:0] LAST   = CW'(TOT - 1);
  localparam logic [TW-1:0] ST_END = TW'(SETTLE_CYC);
  localparam logic [TW-1:0] WT_END = TW'(WAIT_CYC - 1);
  localparam logic [TW-1:0] RS_END = TW'(RES_STRIDE - 1);
  localparam logic [JW-1:0] JLAST  = JW'(N - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, CAPTURE, OUTPUT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [JW-1:0] j, j_d;
  logic [WORD_SIZE-1:0] res_buf [N];
  logic acc, samp, ohs;
  logic rdy_d, busy_d, we_d, ov_d, ol_d;
  logic [ADDRS_LEN-1:0] addr_d;
  logic [WORD_SIZE-1:0] data_d, od_d;
  // flush masks both handshakes so a word offered alongside it is dropped
  assign acc  = bus.in_valid & bus.in_ready & ~flush;
  assign ohs  = bus.out_valid & bus.out_ready & ~flush;
  assign samp = state == CAPTURE && tcnt == '0;
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      tcnt           <= '0;
      j              <= '0;
      busy           <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.mm_we      <= 1'b0;
      bus.mm_addr    <= '0;
      bus.mm_data_wr <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_data   <= '0;
      bus.out_qi     <= '0;
      bus.out_qf     <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      tcnt           <= tcnt_d;
      j              <= j_d;
      busy           <= busy_d;
      bus.in_ready   <= rdy_d;
      bus.mm_we      <= we_d;
      bus.mm_addr    <= addr_d;
      bus.mm_data_wr <= data_d;
      bus.out_valid  <= ov_d;
      bus.out_last   <= ol_d;
      bus.out_data   <= od_d;
      if (samp && j == '0 && !flush) begin
        bus.out_qi <= bus.mm_qi;
        bus.out_qf <= bus.mm_qf;
      end
    end
  end
  always_ff @(posedge src_clk)
    if (samp && !flush) res_buf[j] <= bus.mm_result;
  always_comb begin
    state_d = state;
    if (flush) state_d = IDLE;
    else
      case (state)
        IDLE:    if (acc) state_d = LOAD;
        LOAD:    if (acc && cnt == LAST) state_d = SETTLE;
        SETTLE:  if (tcnt == ST_END) state_d = WAIT;
        WAIT:    if (tcnt == WT_END) state_d = CAPTURE;
        CAPTURE: if (samp && j == JLAST) state_d = OUTPUT;
        OUTPUT:  if (ohs && j == JLAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  // registered outputs are computed from the next state so they line up with it
  always_comb begin
    cnt_d  = state_d == IDLE ? '0 : cnt + CW'(acc);
    tcnt_d = state_d != state ? '0 :
             (state == SETTLE || state == WAIT || (state == CAPTURE && tcnt != RS_END)) ? tcnt + TW'(1) : '0;
    j_d    = (state_d == IDLE || (state == CAPTURE && state_d == OUTPUT)) ? '0 :
             (samp || ohs) ? j + JW'(1) : j;
    rdy_d  = state_d == IDLE || state_d == LOAD;
    busy_d = state_d != IDLE;
    we_d   = acc || state_d == SETTLE;
    addr_d = acc ? ADDRS_LEN'(cnt) : (state_d == LOAD || state_d == SETTLE) ? bus.mm_addr : '0;
    data_d = acc ? bus.in_data : bus.mm_data_wr;
    ov_d   = state_d == OUTPUT;
    ol_d   = ov_d && j_d == JLAST;
    od_d   = ov_d ? res_buf[j_d] : bus.out_data;
  end
endmodule

// File: tb/tb_matmul_load_sequencer.sv
// tb_matmul_load_sequencer: table vectors, directed jobs and random jobs against a matrix-vector model
module tb_matmul_load_sequencer;
  localparam int SETTLE_CYC = 4;
  localparam int WAIT_CYC   = 50;
  localparam int RES_STRIDE = 1;
  typedef logic [15:0] job_t [72];
  typedef logic [15:0] res_t [8];
  typedef struct {
    logic v; logic [15:0] d; logic f;
    logic rdy; logic we; logic [6:0] addr; logic [15:0] wd; logic busy;
  } vec_t;
  logic src_clk, rst_n, flush, busy;
  int n_cmp, n_bad;
  matmul_load_sequencer_if #(.WORD_SIZE(16), .ADDRS_LEN(7)) b();
  matmul_load_sequencer #(
    .WORD_SIZE(16), .ADDRS_LEN(7), .N(8),
    .SETTLE_CYC(SETTLE_CYC), .WAIT_CYC(WAIT_CYC), .RES_STRIDE(RES_STRIDE)
  ) dut (
    .src_clk(src_clk), .rst_n(rst_n), .flush(flush), .bus(b), .busy(busy)
  );
  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;
  function automatic logic [15:0] rowres(input job_t w, input int i, input int qf);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'($signed(w[i*8+k])) * longint'($signed(w[64+k]));
    return 16'(s >>> qf);
  endfunction
  function automatic res_t ref_res(input job_t w, input int qf);
    res_t r;
    for (int i = 0; i < 8; i++) r[i] = rowres(w, i, qf);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // stand-in core: memory written through the port, results presented WAIT_CYC cycles after we falls
  logic [15:0] mem [128];
  bit prev_we, running;
  int c;
  res_t cres;
  always @(negedge src_clk) begin
    job_t m;
    if (b.mm_we) begin
      mem[b.mm_addr] = b.mm_data_wr;
      running = 0;
    end else if (prev_we) begin
      for (int k = 0; k < 72; k++) m[k] = mem[k];
      cres = ref_res(m, int'(b.mm_qf));
      running = 1;
      c = 0;
    end else if (running) c++;
    prev_we = b.mm_we;
    b.mm_result = (running && c >= WAIT_CYC && (c - WAIT_CYC) % RES_STRIDE == 0 && (c - WAIT_CYC) / RES_STRIDE < 8)
                  ? cres[(c - WAIT_CYC) / RES_STRIDE] : 16'hDEAD;
  end
  // gap: 0 always valid, 1 alternate, 2 random; abort: 0 none, 1 flush, 2 reset at abort_addr
  task automatic run_job(input job_t w, input res_t exp, input int gap, input int bp_at, input bit rnd_rdy,
                         input int abort_kind, input int abort_addr, input bit chk_timing);
    int idx = 0, wn = 0, oi = 0, cyc = 0, t_first = 0, t_last = 0, stall = 0;
    bit fell = 0, done = 0;
    while (!done) begin
      @(negedge src_clk);
      cyc++;
      if (cyc > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL job_timeout: got %0d results want 8", oi);
        break;
      end
      if (oi == 8) begin
        chk("end_busy", busy, 0);
        chk("end_valid", b.out_valid, 0);
        chk("end_ready", b.in_ready, 1);
        done = 1;
      end else begin
        if (idx == 72) chk("ready_low", b.in_ready, 0);
        if (b.mm_we) begin
          if (wn < 72) begin
            chk("wr_addr", b.mm_addr, wn);
            chk("wr_data", b.mm_data_wr, w[wn]);
            if (wn == 0) t_first = cyc;
            if (wn == 71) t_last = cyc;
          end else chk("settle_addr", b.mm_addr, 71);
          wn++;
        end else if (wn >= 72 && !fell) begin
          fell = 1;
          chk("settle_len", wn, 72 + SETTLE_CYC);
          if (chk_timing) chk("load_span", t_last - t_first, 71);
        end
        if (abort_kind == 2 && b.mm_we && b.mm_addr == 7'(abort_addr)) begin
          rst_n = 0;
          #1;
          chk("reset_state", {b.in_ready, b.mm_we, b.mm_addr, b.mm_data_wr, b.out_valid, b.out_last,
                              b.out_data, b.out_qi, b.out_qf, busy}, {1'b1, 51'd0});
          b.in_valid = 0;
          @(negedge src_clk);
          rst_n = 1;
          return;
        end
        if (abort_kind == 1 && b.mm_we && b.mm_addr == 7'(abort_addr)) begin
          flush = 1;
          b.in_valid = 1;
          b.in_data = 16'hBEEF;
          @(negedge src_clk);
          flush = 0;
          b.in_valid = 0;
          chk("flush_busy", busy, 0);
          chk("flush_we", b.mm_we, 0);
          chk("flush_ready", b.in_ready, 1);
          return;
        end
        if (b.out_valid) begin
          chk("out_data", b.out_data, exp[oi]);
          chk("out_last", b.out_last, oi == 7);
          chk("out_fmt", {b.out_qi, b.out_qf}, {b.mm_qi, b.mm_qf});
        end
        b.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : !(b.out_valid && oi == bp_at && stall < 5);
        if (b.out_valid && !b.out_ready && oi == bp_at) stall++;
        if (b.out_valid && b.out_ready) oi++;
        b.in_valid = idx < 72 && (gap == 0 ? 1'b1 : gap == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1)));
        b.in_data = idx < 72 ? w[idx] : 16'h0;
        if (b.in_valid && b.in_ready) idx++;
      end
    end
    b.in_valid = 0;
    b.out_ready = 1;
  endtask
  initial begin
    vec_t tbl[7];
    job_t w;
    res_t e;
    tbl[0] = '{1, 16'h1111, 0, 1, 1, 7'd0, 16'h1111, 1};
    tbl[1] = '{0, 16'h2222, 0, 1, 0, 7'd0, 16'h1111, 1};
    tbl[2] = '{1, 16'h3333, 0, 1, 1, 7'd1, 16'h3333, 1};
    tbl[3] = '{1, 16'h4444, 1, 1, 0, 7'd0, 16'h3333, 0};
    tbl[4] = '{1, 16'h5555, 0, 1, 1, 7'd0, 16'h5555, 1};
    tbl[5] = '{0, 16'h6666, 1, 1, 0, 7'd0, 16'h5555, 0};
    tbl[6] = '{0, 16'h7777, 0, 1, 0, 7'd0, 16'h5555, 0};
    n_cmp = 0; n_bad = 0;
    rst_n = 0; flush = 0;
    b.in_valid = 0; b.in_data = 0; b.out_ready = 1; b.mm_qi = 4'd7; b.mm_qf = 4'd8;
    repeat (3) @(negedge src_clk);
    rst_n = 1;
    @(negedge src_clk);
    chk("idle_state", {b.in_ready, b.mm_we, b.mm_addr, b.mm_data_wr, b.out_valid, b.out_last,
                       b.out_data, b.out_qi, b.out_qf, busy}, {1'b1, 51'd0});
    for (int i = 0; i < 7; i++) begin
      b.in_valid = tbl[i].v; b.in_data = tbl[i].d; flush = tbl[i].f;
      @(negedge src_clk);
      chk($sformatf("tbl%0d", i), {b.in_ready, b.mm_we, b.mm_addr, b.mm_data_wr, busy},
          {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].busy});
    end
    b.in_valid = 0; flush = 0;
    for (int k = 0; k < 72; k++) w[k] = 16'(k + 1);
    run_job(w, ref_res(w, 8), 0, -1, 0, 0, 0, 1);
    run_job(w, ref_res(w, 8), 0, -1, 0, 2, 30, 0);
    run_job(w, ref_res(w, 8), 1, -1, 0, 0, 0, 0);
    run_job(w, ref_res(w, 8), 0, 3, 0, 0, 0, 0);
    run_job(w, ref_res(w, 8), 0, -1, 0, 1, 40, 0);
    for (int k = 0; k < 72; k++) w[k] = 16'($urandom);
    run_job(w, ref_res(w, 8), 0, -1, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) w[k] = (k / 8 == k % 8) ? 16'h0100 : 16'h0000;
    for (int k = 0; k < 8; k++) begin
      w[64+k] = 16'((k + 1) * 256);
      e[k] = 16'((k + 1) * 256);
    end
    run_job(w, e, 0, -1, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      b.mm_qi = 4'($urandom_range(0, 15));
      b.mm_qf = 4'($urandom_range(0, 15));
      for (int k = 0; k < 72; k++) w[k] = 16'($urandom);
      run_job(w, ref_res(w, int'(b.mm_qf)), 2, -1, 1, 0, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
